// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the RV32 memory-access stage.
//   mem_op_t     - memory op code carried from EX/MEM
//   mem_state_t  - access FSM states
//   NOP_REG_ADDR - destination register used when nothing is written back
//   MASK_*       - byte-strobe masks for byte/halfword/word accesses
package mem_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LW   = 4'd3,
    MOP_LBU  = 4'd4,
    MOP_LHU  = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT1,
    ST_REQ2,
    ST_WAIT2,
    ST_DONE
  } mem_state_t;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for one load/store.
//   op, off          - op code and byte offset within the word
//   st_data          - store data (unshifted)
//   beat1, beat2     - raw read words of the first / second beat
//   is_load/is_store - op classification
//   split            - access crosses a word boundary (two beats)
//   misaligned       - access is not naturally aligned
//   wdata1/2, be1/2  - shifted store data and strobes for each beat
//   ld_data          - extracted and extended load result
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] beat1,
  input  logic [31:0] beat2,
  output logic        is_load,
  output logic        is_store,
  output logic        split,
  output logic        misaligned,
  output logic [31:0] wdata1,
  output logic [31:0] wdata2,
  output logic [3:0]  be1,
  output logic [3:0]  be2,
  output logic [31:0] ld_data
);

  logic        is_half, is_word;
  logic [3:0]  mask;
  logic [4:0]  sh;
  logic [63:0] wfull;
  logic [7:0]  be_full;
  logic [31:0] ld_word;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (op)
      MOP_LB, MOP_LBU: is_load = 1'b1;
      MOP_LH, MOP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      MOP_LW:          begin is_load = 1'b1; is_word = 1'b1; end
      MOP_SB:          is_store = 1'b1;
      MOP_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      MOP_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign mask       = is_word ? MASK_W : (is_half ? MASK_H : MASK_B);
  assign split      = (is_half && off == 2'd3) || (is_word && off != 2'd0);
  assign misaligned = (is_half && off[0]) || (is_word && off != 2'd0);
  assign sh         = {off, 3'b000};

  // Shift into a double-word window: the low half is beat 1, whatever
  // spills past bit 31 (or strobe bit 3) belongs to beat 2.
  assign wfull   = {32'd0, st_data} << sh;
  assign be_full = {4'd0, mask} << off;
  assign wdata1  = wfull[31:0];
  assign wdata2  = wfull[63:32];
  assign be1     = be_full[3:0];
  assign be2     = be_full[7:4];

  assign ld_word = 32'({beat2, beat1} >> sh);

  always_comb begin
    case (op)
      MOP_LB:  ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      MOP_LBU: ld_data = {24'd0, ld_word[7:0]};
      MOP_LH:  ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      MOP_LHU: ld_data = {16'd0, ld_word[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32 MEM stage. Turns one load/store into one or two
// aligned RAM beats, stalls the pipeline until the result is ready and
// passes non-memory instructions straight through.
//   clk, rst                  - clock, async active-low reset
//   wd_i/wreg_i/wdata_i       - write-back info / ALU result / store data
//   op_i, addr_i              - memory op and effective byte address
//   ram_rdata_i/done_i/busy_i - RAM response side
//   wd_o/wreg_o/wdata_o       - write-back to MEM/WB
//   stall_req_o               - freeze the pipeline
//   ram_re_o/we_o/addr_o/wdata_o/be_o - RAM request side (one-cycle strobes)
//   misalign_o                - rejected misaligned access (ALLOW_MISALIGN=0)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       ram_rdata_i,
  input  logic              ram_done_i,
  input  logic              ram_busy_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o,
  output logic              ram_re_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_be_o,
  output logic              misalign_o
);

  mem_state_t        state;
  logic [31:0]       beat1_q;
  logic [31:0]       res_wdata;
  logic [4:0]        res_wd;
  logic              res_wreg;

  logic              is_load, is_store, is_mem, split, misaligned, reject;
  logic [31:0]       wdata1, wdata2, ld_data, lane_b1, lane_b2;
  logic [3:0]        be1, be2;
  logic [ADDR_W-3:0] widx, widx_nxt;

  // Beat 1 comes straight off the bus unless we are completing a split
  // access, in which case it was latched and beat 2 is on the bus.
  assign lane_b1 = (state == ST_WAIT2) ? beat1_q     : ram_rdata_i;
  assign lane_b2 = (state == ST_WAIT2) ? ram_rdata_i : 32'd0;

  mem_lane_align u_align (
    .op         (mem_op_t'(op_i)),
    .off        (addr_i[1:0]),
    .st_data    (wdata_i),
    .beat1      (lane_b1),
    .beat2      (lane_b2),
    .is_load    (is_load),
    .is_store   (is_store),
    .split      (split),
    .misaligned (misaligned),
    .wdata1     (wdata1),
    .wdata2     (wdata2),
    .be1        (be1),
    .be2        (be2),
    .ld_data    (ld_data)
  );

  assign is_mem   = is_load | is_store;
  assign reject   = (ALLOW_MISALIGN == 0) && misaligned;
  assign widx     = addr_i[ADDR_W-1:2];
  assign widx_nxt = widx + {{(ADDR_W-3){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      beat1_q   <= '0;
      res_wdata <= '0;
      res_wd    <= NOP_REG_ADDR;
      res_wreg  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (is_mem && !reject && !ram_busy_i) state <= ST_WAIT1;
        ST_WAIT1:
          if (ram_done_i) begin
            beat1_q <= ram_rdata_i;
            if (split) state <= ST_REQ2;
            else begin
              res_wdata <= is_load ? ld_data : 32'd0;
              res_wd    <= is_load ? wd_i : NOP_REG_ADDR;
              res_wreg  <= is_load & wreg_i;
              state     <= ST_DONE;
            end
          end
        ST_REQ2:
          if (!ram_busy_i) state <= ST_WAIT2;
        ST_WAIT2:
          if (ram_done_i) begin
            res_wdata <= is_load ? ld_data : 32'd0;
            res_wd    <= is_load ? wd_i : NOP_REG_ADDR;
            res_wreg  <= is_load & wreg_i;
            state     <= ST_DONE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request strobes are combinational off the state so beat 1 issues in the
  // same cycle the op arrives; gating with ram_busy_i keeps them off a busy bus.
  always_comb begin
    wd_o        = NOP_REG_ADDR;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    stall_req_o = 1'b0;
    ram_re_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'd0;
    ram_be_o    = 4'd0;
    misalign_o  = 1'b0;
    if (rst) begin
      if (state == ST_DONE) begin
        wd_o    = res_wd;
        wreg_o  = res_wreg;
        wdata_o = res_wdata;
      end else if (!is_mem) begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
      end else begin
        stall_req_o = 1'b1;
        case (state)
          ST_IDLE:
            if (reject) begin
              stall_req_o = 1'b0;
              misalign_o  = 1'b1;
            end else if (!ram_busy_i) begin
              ram_re_o    = is_load;
              ram_we_o    = is_store;
              ram_addr_o  = {widx, 2'b00};
              ram_wdata_o = is_store ? wdata1 : 32'd0;
              ram_be_o    = be1;
            end
          ST_REQ2:
            if (!ram_busy_i) begin
              ram_re_o    = is_load;
              ram_we_o    = is_store;
              ram_addr_o  = {widx_nxt, 2'b00};
              ram_wdata_o = is_store ? wdata2 : 32'd0;
              ram_be_o    = be2;
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk, rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  op_i, nm_op;
  logic [31:0] addr_i, nm_addr;
  logic [31:0] ram_rdata_i;
  logic        ram_done_i, ram_busy_i;

  logic [4:0]  wd_o, nm_wd;
  logic        wreg_o, nm_wreg;
  logic [31:0] wdata_o, nm_wdata;
  logic        stall_req_o, nm_stall;
  logic        ram_re_o, ram_we_o, nm_re, nm_we;
  logic [31:0] ram_addr_o, nm_raddr;
  logic [31:0] ram_wdata_o, nm_rwdata;
  logic [3:0]  ram_be_o, nm_be;
  logic        misalign_o, nm_misalign;

  mem_access_unit #(.ADDR_W(32), .ALLOW_MISALIGN(1)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .op_i(op_i), .addr_i(addr_i), .ram_rdata_i(ram_rdata_i),
    .ram_done_i(ram_done_i), .ram_busy_i(ram_busy_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
    .ram_re_o(ram_re_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .misalign_o(misalign_o)
  );

  mem_access_unit #(.ADDR_W(32), .ALLOW_MISALIGN(0)) dut_nm (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .op_i(nm_op), .addr_i(nm_addr), .ram_rdata_i(ram_rdata_i),
    .ram_done_i(ram_done_i), .ram_busy_i(ram_busy_i),
    .wd_o(nm_wd), .wreg_o(nm_wreg), .wdata_o(nm_wdata), .stall_req_o(nm_stall),
    .ram_re_o(nm_re), .ram_we_o(nm_we), .ram_addr_o(nm_raddr),
    .ram_wdata_o(nm_rwdata), .ram_be_o(nm_be), .misalign_o(nm_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Results of the last run_op
  int          r_stalls, r_nreq, r_busy_strobe;
  logic        r_ok;
  logic [31:0] r_a1, r_a2, r_d1, r_d2, r_res;
  logic [3:0]  r_b1, r_b2;
  logic [4:0]  r_wd;
  logic        r_wreg;

  // Drive one op and play a RAM that answers the cycle after each request.
  // busy_n: number of leading cycles with ram_busy_i high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [4:0] wd,
                        input logic wreg, input int busy_n,
                        input logic [31:0] r1, input logic [31:0] r2);
    int   busy_left;
    logic req_now;
    @(negedge clk);
    op_i = op; addr_i = addr; wdata_i = wdat; wd_i = wd; wreg_i = wreg;
    busy_left = busy_n; ram_busy_i = (busy_left > 0); ram_done_i = 1'b0;
    r_stalls = 0; r_nreq = 0; r_busy_strobe = 0; r_ok = 1'b0;
    r_a1 = '0; r_a2 = '0; r_d1 = '0; r_d2 = '0; r_b1 = '0; r_b2 = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall_req_o) begin
        r_res = wdata_o; r_wd = wd_o; r_wreg = wreg_o; r_ok = 1'b1;
        break;
      end
      r_stalls++;
      req_now = ram_re_o | ram_we_o;
      if (req_now && ram_busy_i) r_busy_strobe++;
      if (req_now) begin
        if (r_nreq == 0) begin r_a1 = ram_addr_o; r_d1 = ram_wdata_o; r_b1 = ram_be_o; end
        else             begin r_a2 = ram_addr_o; r_d2 = ram_wdata_o; r_b2 = ram_be_o; end
        r_nreq++;
      end
      @(negedge clk);
      ram_done_i  = req_now;
      ram_rdata_i = (r_nreq <= 1) ? r1 : r2;
      if (busy_left > 0) busy_left--;
      ram_busy_i = (busy_left > 0);
    end
    @(negedge clk);
    op_i = MOP_NONE; ram_done_i = 1'b0; ram_busy_i = 1'b0; wreg_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; op_i = MOP_LW; nm_op = MOP_NONE; addr_i = 32'h100; nm_addr = '0;
    wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'h1234;
    ram_rdata_i = '0; ram_done_i = 1'b0; ram_busy_i = 1'b0;

    // Reset: outputs forced low even with a load presented
    @(negedge clk); #1;
    chk("rst_stall", stall_req_o, 0);
    chk("rst_re", ram_re_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wreg", wreg_o, 0);

    @(negedge clk); op_i = MOP_NONE; rst = 1'b1;

    // Pass-through
    @(negedge clk); op_i = MOP_NONE; wdata_i = 32'h1234; wd_i = 5'd5; wreg_i = 1'b1; #1;
    chk("pt_wdata", wdata_o, 32'h1234);
    chk("pt_wd", wd_o, 5);
    chk("pt_wreg", wreg_o, 1);
    chk("pt_stall", stall_req_o, 0);
    chk("pt_strobes", {ram_re_o, ram_we_o, ram_be_o}, 0);

    // LB at 0x102, sign extend
    run_op(MOP_LB, 32'h102, 32'h0, 5'd7, 1'b1, 0, 32'h0080_0000, 32'h0);
    chk("lb_ok", r_ok, 1);
    chk("lb_addr", r_a1, 32'h100);
    chk("lb_stalls", r_stalls, 2);
    chk("lb_data", r_res, 32'hFFFF_FF80);
    chk("lb_wd", r_wd, 7);
    chk("lb_wreg", r_wreg, 1);

    // LHU at 0x102, zero extend
    run_op(MOP_LHU, 32'h102, 32'h0, 5'd9, 1'b1, 0, 32'h8001_0000, 32'h0);
    chk("lhu_data", r_res, 32'h0000_8001);
    chk("lhu_stalls", r_stalls, 2);

    // SH at 0x105
    run_op(MOP_SH, 32'h105, 32'h0000_BEEF, 5'd3, 1'b1, 0, 32'h0, 32'h0);
    chk("sh_nreq", r_nreq, 1);
    chk("sh_addr", r_a1, 32'h104);
    chk("sh_be", r_b1, 4'b0110);
    chk("sh_wdata", r_d1, 32'h00BE_EF00);
    chk("sh_wreg", r_wreg, 0);
    chk("sh_wd", r_wd, 0);

    // Split SW at 0x106
    run_op(MOP_SW, 32'h106, 32'h1122_3344, 5'd3, 1'b1, 0, 32'h0, 32'h0);
    chk("sws_nreq", r_nreq, 2);
    chk("sws_a1", r_a1, 32'h104);
    chk("sws_d1", r_d1, 32'h3344_0000);
    chk("sws_b1", r_b1, 4'b1100);
    chk("sws_a2", r_a2, 32'h108);
    chk("sws_d2", r_d2, 32'h0000_1122);
    chk("sws_b2", r_b2, 4'b0011);
    chk("sws_stalls", r_stalls, 4);

    // Split LW at 0x203
    run_op(MOP_LW, 32'h203, 32'h0, 5'd11, 1'b1, 0, 32'hAA00_0000, 32'h00CC_BBDD);
    chk("lws_a1", r_a1, 32'h200);
    chk("lws_a2", r_a2, 32'h204);
    chk("lws_data", r_res, 32'hCCBB_DDAA);
    chk("lws_stalls", r_stalls, 4);
    chk("lws_wd", r_wd, 11);

    // Split LH at 0x103, negative halfword across the boundary
    run_op(MOP_LH, 32'h103, 32'h0, 5'd12, 1'b1, 0, 32'h1200_0000, 32'h0000_00F4);
    chk("lhs_nreq", r_nreq, 2);
    chk("lhs_data", r_res, 32'hFFFF_F412);

    // Busy for 3 cycles at LW issue
    run_op(MOP_LW, 32'h300, 32'h0, 5'd13, 1'b1, 3, 32'hDEAD_BEEF, 32'h0);
    chk("busy_strobe", r_busy_strobe, 0);
    chk("busy_nreq", r_nreq, 1);
    chk("busy_stalls", r_stalls, 5);
    chk("busy_data", r_res, 32'hDEAD_BEEF);

    // Misaligned SW rejected when splitting is disabled
    @(negedge clk); nm_op = MOP_SW; nm_addr = 32'h6; wreg_i = 1'b1; #1;
    chk("rej_misalign", nm_misalign, 1);
    chk("rej_stall", nm_stall, 0);
    chk("rej_req", {nm_re, nm_we}, 0);
    chk("rej_wreg", nm_wreg, 0);
    @(negedge clk); nm_op = MOP_NONE; wreg_i = 1'b0; #1;
    chk("rej_pulse_end", nm_misalign, 0);

    // Reset in WAIT1, then a stray done after release
    @(negedge clk); op_i = MOP_LW; addr_i = 32'h400; wd_i = 5'd3; wreg_i = 1'b1;
    @(negedge clk); #1;
    chk("rmid_wait_stall", stall_req_o, 1);
    rst = 1'b0; #1;
    chk("rmid_stall", stall_req_o, 0);
    chk("rmid_re", ram_re_o, 0);
    op_i = MOP_NONE; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
    @(negedge clk); rst = 1'b1; ram_done_i = 1'b1; ram_rdata_i = 32'h5555_AAAA; #1;
    chk("rmid_done_stall", stall_req_o, 0);
    @(negedge clk); ram_done_i = 1'b0; #1;
    chk("rmid_wreg", wreg_o, 0);
    chk("rmid_wdata", wdata_o, 0);
    run_op(MOP_LW, 32'h500, 32'h0, 5'd14, 1'b1, 0, 32'h0BAD_F00D, 32'h0);
    chk("rmid_next_stalls", r_stalls, 2);
    chk("rmid_next_data", r_res, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential, parametrised memory-access stage of the RV32 pipeline, between the EX/MEM and MEM/WB pipeline registers. It turns one load/store per instruction into one or two aligned bus transactions on the RAM port. It supports byte-lane strobes and optional split handling of misaligned accesses. It raises `stall_req_o` until the result is ready; non-memory instructions pass through with zero latency.

## Interface
- `ADDR_W`, 32: RAM address width.
- `ALLOW_MISALIGN`, 1: 1 = split misaligned accesses into two beats; 0 = reject them with `misalign_o`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wd_i` in 5: destination register.
- `wreg_i` in 1: write-back enable.
- `wdata_i` in 32: ALU result, or store data.
- `op_i` in 4: memory op code (`MOP_NONE`, LB, LH, LW, LBU, LHU, SB, SH, SW).
- `addr_i` in ADDR_W: effective byte address.
- `ram_rdata_i` in 32: read data; valid in the `ram_done_i` cycle.
- `ram_done_i` in 1: one-cycle completion pulse.
- `ram_busy_i` in 1: RAM cannot accept a request this cycle.
- `wd_o`, `wreg_o`, `wdata_o` out 5/1/32: write-back signals.
- `stall_req_o` out 1: freeze pipeline.
- `ram_re_o`, `ram_we_o` out 1: one-cycle request strobes.
- `ram_addr_o` out ADDR_W: word-aligned address (low 2 bits = 0).
- `ram_wdata_o` out 32: lane-shifted store data.
- `ram_be_o` out 4: byte strobes.
- `misalign_o` out 1: one-cycle pulse for a rejected misaligned access.

## Operation
- `op_i == MOP_NONE` (any state except DONE):
  - outputs follow `wd_i`/`wreg_i`/`wdata_i` combinationally;
  - `stall_req_o` = 0; no bus activity.
- States:
  - IDLE: a memory op is present, so `stall_req_o` = 1.
    - `!ram_busy_i`: issue beat 1, go to WAIT1.
    - `ram_busy_i`: stay in IDLE and issue nothing.
    - `ALLOW_MISALIGN` = 0 and the access is misaligned: no request; pulse `misalign_o`; `stall_req_o` = 0; `wreg_o` = 0; stay in IDLE.
  - WAIT1: `stall_req_o` = 1. On `ram_done_i`, latch the data; go to REQ2 if split, else to DONE.
  - REQ2: issue beat 2 at `{addr[ADDR_W-1:2]+1, 2'b00}` when `!ram_busy_i`, then go to WAIT2.
  - WAIT2: on `ram_done_i`, go to DONE.
  - DONE: drive the registered result; `stall_req_o` = 0, so the pipeline advances on this edge; go to IDLE.
- Split rule, with off = `addr_i[1:0]`: split if halfword and off = 3, or word and off ≠ 0. Bytes are never split.
- Store beat 1:
  - `ram_wdata_o` = `wdata_i << 8*off`;
  - `ram_be_o` = (size mask `0001`/`0011`/`1111`) `<< off`, truncated to 4 bits.
- Store beat 2: data `wdata_i >> 8*(4-off)`; strobes = the bits shifted out above bit 3.
- Load assembly: `{beat2, beat1} >> 8*off`, then:
  - LB/LH sign-extend from bit 7/15 to 32 bits;
  - LBU/LHU zero-extend;
  - LW takes the full 32 bits.
- Write-back in DONE:
  - loads: `wd_o` = `wd_i`, `wreg_o` = `wreg_i`;
  - stores: `wreg_o` = 0, `wd_o` = 0.
- Boundary rules:
  - `ram_done_i` in IDLE, REQ2 or DONE is ignored.
  - `ram_busy_i` together with `ram_done_i` in WAIT: done wins.
  - Inputs are held stable while `stall_req_o` = 1; the unit does not re-sample them.

## Timing
- Reset (async assert): state = IDLE; every output = 0; latched data cleared. An in-flight `ram_done_i` after reset release is ignored.
- Aligned access, RAM answering in the next cycle:
  - cycle 0 request;
  - cycle 1 done;
  - cycle 2 DONE, so `stall_req_o` is high for 2 cycles.
- Split access, no wait states: 4 stall cycles, then DONE.
- `ram_re_o`/`ram_we_o` are high for exactly one cycle per beat and never while `ram_busy_i` = 1.
- Pass-through and the misalign rejection both have 0-cycle latency.

## Structure
- Package `mem_pkg` contains:
  - `mem_op_t` enum;
  - `mem_state_t` (IDLE, WAIT1, REQ2, WAIT2, DONE);
  - `NOP_REG_ADDR`;
  - size-mask constants.
- Sub-module `mem_lane_align` (combinational): computes store shift and strobes for both beats, the split flag, and load extraction/extension. Instantiated once.
- The top level holds the FSM, beat-1 data latch, and result register.

## Test plan
- Pass-through: `op_i` = NONE, `wdata_i` = 0x1234 → `wdata_o` = 0x1234 in the same cycle; `stall_req_o` = 0; no strobes.
- Sign extension: LB at 0x102, RAM returns 0x00800000 → `wdata_o` = 0xFFFFFF80. LHU at 0x102, RAM returns 0x80010000 → `wdata_o` = 0x00008001.
- Store strobes: SH at 0x105 with `wdata_i` = 0xBEEF → `ram_addr_o` = 0x104, `ram_be_o` = 0110, `ram_wdata_o` = 0x00BEEF00; `wreg_o` = 0.
- Split load: LW at 0x203, beats return 0xAA000000 and 0x00CCBBDD → requests go to 0x200 then 0x204; `wdata_o` = 0xCCBBDDAA; 4 stall cycles.
- Busy and reject:
  - `ram_busy_i` high for 3 cycles at LW issue → no strobe until busy drops.
  - With `ALLOW_MISALIGN` = 0, SW at 0x6 → `misalign_o` pulses; no request.
- Reset mid-op: assert `rst` low in WAIT1, then deliver `ram_done_i` after release → all outputs 0, state IDLE, no write-back.
